max7219_spi_arbiter: RTL and testbench

MAX7219_SPI_ARBITER -- requirements
Module: max7219_spi_arbiter

---
 rtl/max7219_pkg.sv | 39 +++
 rtl/rr_pick.sv | 28 ++
 rtl/max7219_spi_arbiter.sv | 112 +++++++++++
 tb/tb_max7219_spi_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared types and MAX7219 register map for the SPI arbiter slice.
package max7219_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        SHIFT,
        GAP
    } state_t;

    localparam logic [7:0] ADDR_DIGIT0       = 8'h01;
    localparam logic [7:0] ADDR_DIGIT1       = 8'h02;
    localparam logic [7:0] ADDR_DIGIT2       = 8'h03;
    localparam logic [7:0] ADDR_DIGIT3       = 8'h04;
    localparam logic [7:0] ADDR_DIGIT4       = 8'h05;
    localparam logic [7:0] ADDR_DIGIT5       = 8'h06;
    localparam logic [7:0] ADDR_DIGIT6       = 8'h07;
    localparam logic [7:0] ADDR_DIGIT7       = 8'h08;
    localparam logic [7:0] ADDR_DECODE       = 8'h09;
    localparam logic [7:0] ADDR_INTENSITY    = 8'h0A;
    localparam logic [7:0] ADDR_SCAN_LIMIT   = 8'h0B;
    localparam logic [7:0] ADDR_SHUTDOWN     = 8'h0C;
    localparam logic [7:0] ADDR_DISPLAY_TEST = 8'h0F;

    function automatic logic [WORD_W-1:0] mk_frame(input logic [7:0] addr, input logic [7:0] value);
        return {addr, value};
    endfunction

    function automatic logic is_reg_addr(input logic [7:0] addr);
        return addr inside {ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7,
                            ADDR_DECODE, ADDR_INTENSITY, ADDR_SCAN_LIMIT,
                            ADDR_SHUTDOWN, ADDR_DISPLAY_TEST};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/max7219_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ MAX7219 frame sources,
// with CS framing, busy-lag settle cycle, timeout abort and inter-frame CS gap.
module max7219_spi_arbiter
    import max7219_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int CS_GAP  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [WORD_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic                   error,
    output logic                   spi_start,
    output logic [WORD_W-1:0]      spi_data,
    input  logic                   spi_busy,
    output logic                   CS
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     nptr;
    logic [NREQ-1:0]   pick;
    logic              pick_vld;
    logic [NREQ-1:0]   cur;
    logic [WORD_W-1:0] sel_data;
    logic [TW-1:0]     tcnt;
    logic [3:0]        gcnt;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    // Winner's frame and the pointer slot just past it.
    always_comb begin
        sel_data = '0;
        nptr     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                sel_data = req_data[WORD_W*i +: WORD_W];
                nptr     = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
            grant     <= '0;
            done      <= '0;
            error     <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            CS        <= 1'b1;
        end else begin
            grant     <= '0;
            done      <= '0;
            error     <= 1'b0;
            spi_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= START;
                        grant     <= pick;
                        cur       <= pick;
                        spi_data  <= sel_data;
                        spi_start <= 1'b1;
                        CS        <= 1'b0;
                        ptr       <= nptr;
                        tcnt      <= '0;
                    end
                end
                START:  state <= SETTLE;
                SETTLE: state <= SHIFT;
                SHIFT: begin
                    if (!spi_busy) begin
                        done  <= cur;
                        CS    <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        CS    <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == 4'(CS_GAP - 1)) state <= IDLE;
                    else                        gcnt  <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_spi_arbiter.sv
// Directed bench for max7219_spi_arbiter with a simple SPI busy model.
module tb_max7219_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  grant, done;
    logic        error, spi_start, spi_busy, CS;
    logic [15:0] spi_data;

    logic [7:0]  blen  = 8'd17;
    logic        stuck = 1'b0;
    logic [7:0]  bcnt;

    int checks = 0;
    int passed = 0;

    max7219_spi_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .error(error),
        .spi_start(spi_start), .spi_data(spi_data),
        .spi_busy(spi_busy), .CS(CS)
    );

    always #500 clk = ~clk;

    // SPI master model: busy rises the cycle after start, holds blen cycles.
    always @(posedge clk) begin
        if (rst)            bcnt <= '0;
        else if (spi_start) bcnt <= blen;
        else if (bcnt != 0) bcnt <= bcnt - 1'b1;
    end
    assign spi_busy = stuck | (bcnt != 0);

    task automatic do_reset();
        rst = 1'b1; req = '0; stuck = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if ({CS, grant, done, error, spi_start} !== 9'b1_000_000_0_0)
            $display("FAIL reset_ctl got %b want 100000000", {CS, grant, done, error, spi_start}); else passed++;
        checks++; if (spi_data !== 16'h0000) $display("FAIL reset_data got %h want 0000", spi_data); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 3'b000 || CS !== 1'b1) $display("FAIL idle_noreq got grant=%b cs=%b want 000/1", grant, CS); else passed++;
    endtask

    task automatic test_single();
        int k;
        do_reset();
        blen = 8'd17; req_data[15:0] = 16'h0C01; req = 3'b001;
        @(negedge clk);
        checks++; if (grant !== 3'b001) $display("FAIL single_grant got %b want 001", grant); else passed++;
        checks++; if (spi_start !== 1'b1 || CS !== 1'b0) $display("FAIL single_start got start=%b cs=%b want 1/0", spi_start, CS); else passed++;
        checks++; if (spi_data !== 16'h0C01) $display("FAIL single_data got %h want 0c01", spi_data); else passed++;
        req = 3'b000;
        @(negedge clk);
        checks++; if (grant !== 3'b000 || spi_start !== 1'b0) $display("FAIL single_pulse got grant=%b start=%b want 000/0", grant, spi_start); else passed++;
        k = 1;
        while (done === 3'b000 && k < 60) begin @(negedge clk); k++; end
        checks++; if (k !== 19 || done !== 3'b001) $display("FAIL single_done got k=%0d done=%b want 19/001", k, done); else passed++;
        checks++; if (CS !== 1'b1 || spi_data !== 16'h0C01) $display("FAIL single_after got cs=%b data=%h want 1/0c01", CS, spi_data); else passed++;
        @(negedge clk);
        checks++; if (done !== 3'b000 || CS !== 1'b1) $display("FAIL single_gap got done=%b cs=%b want 000/1", done, CS); else passed++;
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        blen = 8'd5; req_data[15:0] = 16'h0A05; req = 3'b001;
        k = 0;
        while (grant === 3'b000 && k < 20) begin @(negedge clk); k++; end
        k = 1;
        @(negedge clk);
        while (grant === 3'b000 && k < 60) begin @(negedge clk); k++; end
        checks++; if (k !== 10 || grant !== 3'b001) $display("FAIL b2b_interval got %0d grant=%b want 10/001", k, grant); else passed++;
        req = 3'b000;
    endtask

    task automatic test_contention();
        logic [2:0]  eg [4];
        logic [15:0] ed [4];
        int k;
        eg[0] = 3'b001; eg[1] = 3'b010; eg[2] = 3'b100; eg[3] = 3'b001;
        ed[0] = 16'h0101; ed[1] = 16'h0202; ed[2] = 16'h0303; ed[3] = 16'h0101;
        do_reset();
        blen = 8'd2; req_data = {16'h0303, 16'h0202, 16'h0101}; req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            @(negedge clk);
            while (grant === 3'b000 && k < 40) begin @(negedge clk); k++; end
            checks++; if (grant !== eg[g] || spi_data !== ed[g])
                $display("FAIL contend_%0d got grant=%b data=%h want %b/%h", g, grant, spi_data, eg[g], ed[g]); else passed++;
        end
        req = 3'b000;
    endtask

    task automatic test_late_busy();
        int ndone, at;
        do_reset();
        blen = 8'd3; req_data[31:16] = 16'h0B07; req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        ndone = 0; at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done !== 3'b000) begin ndone++; at = c; end
        end
        checks++; if (ndone !== 1 || at !== 5) $display("FAIL late_busy got n=%0d at=%0d want 1/5", ndone, at); else passed++;
    endtask

    task automatic test_timeout();
        int k, nd;
        do_reset();
        blen = 8'd2; stuck = 1'b1; req_data = {16'h0F00, 16'h0C00, 16'h0901}; req = 3'b011;
        @(negedge clk);
        checks++; if (grant !== 3'b001) $display("FAIL to_grant0 got %b want 001", grant); else passed++;
        req = 3'b010;
        k = 0; nd = 0;
        while (error !== 1'b1 && k < 200) begin
            @(negedge clk); k++;
            if (done !== 3'b000) nd++;
        end
        checks++; if (k !== 66) $display("FAIL to_latency got %0d want 66", k); else passed++;
        checks++; if (CS !== 1'b1 || nd !== 0 || done !== 3'b000) $display("FAIL to_abort got cs=%b ndone=%0d want 1/0", CS, nd); else passed++;
        stuck = 1'b0;
        @(negedge clk);
        checks++; if (error !== 1'b0) $display("FAIL to_pulse got %b want 0", error); else passed++;
        k = 1;
        while (grant === 3'b000 && k < 20) begin @(negedge clk); k++; end
        checks++; if (k !== 3 || grant !== 3'b010 || spi_data !== 16'h0C00)
            $display("FAIL to_next got k=%0d grant=%b data=%h want 3/010/0c00", k, grant, spi_data); else passed++;
        req = 3'b000;
    endtask

    task automatic test_reset_mid();
        int nbad, k;
        do_reset();
        blen = 8'd20; req_data[15:0] = 16'h0102; req = 3'b001;
        @(negedge clk);
        req = 3'b000;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({CS, grant, done, error, spi_start} !== 9'b1_000_000_0_0 || spi_data !== 16'h0000)
            $display("FAIL midrst_out got %b/%h want 100000000/0000", {CS, grant, done, error, spi_start}, spi_data); else passed++;
        nbad = 0;
        repeat (30) begin @(negedge clk); if (done !== 3'b000 || error !== 1'b0) nbad++; end
        checks++; if (nbad !== 0) $display("FAIL midrst_quiet got %0d pulses want 0", nbad); else passed++;
        req_data[31:16] = 16'h0203; req = 3'b011;
        k = 0;
        while (grant === 3'b000 && k < 10) begin @(negedge clk); k++; end
        checks++; if (grant !== 3'b001) $display("FAIL midrst_ptr got %b want 001", grant); else passed++;
        req = 3'b000;
    endtask

    task automatic test_dropped();
        int k, ng;
        do_reset();
        blen = 8'd2; req_data[15:0] = 16'h0A0F; req = 3'b001;
        @(negedge clk);
        req = 3'b000;
        k = 0;
        while (done === 3'b000 && k < 30) begin @(negedge clk); k++; end
        checks++; if (done !== 3'b001) $display("FAIL drop_done got %b want 001", done); else passed++;
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        ng = 0;
        repeat (10) begin @(negedge clk); if (grant !== 3'b000) ng++; end
        checks++; if (ng !== 0) $display("FAIL drop_grant got %0d grants want 0", ng); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_late_busy();
        test_timeout();
        test_reset_mid();
        test_dropped();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
